// File: rtl/slave_internal_response_wr_arbiter.sv
// N-source round-robin arbiter merging internal write responses onto a registered AXI B channel.
// Build option SLAVE_RESP_ERR_PRIORITY_EN: source 0 (error path) gets strict priority over round-robin.
module slave_internal_response_wr_arbiter #(
    parameter int NUM_SOURCES = 2,
    parameter int ID_WIDTH    = 4,
    parameter int RESP_WIDTH  = 2,
    parameter logic [RESP_WIDTH-1:0] RESP_INVALID = {RESP_WIDTH{1'b0}}
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_SOURCES-1:0]            src_bvalid,
    output logic [NUM_SOURCES-1:0]            src_bready,
    input  logic [NUM_SOURCES*ID_WIDTH-1:0]   src_bid,
    input  logic [NUM_SOURCES*RESP_WIDTH-1:0] src_bresp,
    output logic                              BVALID,
    input  logic                              BREADY,
    output logic [ID_WIDTH-1:0]               BID,
    output logic [RESP_WIDTH-1:0]             BRESP
);

    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SOURCES - 1);
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W+1)'(NUM_SOURCES);

    logic                   r_out_valid;
    logic [ID_WIDTH-1:0]    r_out_id;
    logic [RESP_WIDTH-1:0]  r_out_resp;
    logic [PTR_W-1:0]       r_rr_ptr;

    logic                   w_can_load;
    logic                   w_found;
    logic [PTR_W-1:0]       w_winner;
    logic                   w_src_hs;
    logic [NUM_SOURCES-1:0] w_grant;
    logic [ID_WIDTH-1:0]    w_sel_id;
    logic [RESP_WIDTH-1:0]  w_sel_resp;
    logic [PTR_W-1:0]       w_next_ptr;

    // First requester at or above ptr, wrapping; result is {found, index}.
    function automatic logic [PTR_W:0] rr_search(input logic [NUM_SOURCES-1:0] req,
                                                 input logic [PTR_W-1:0]       ptr);
        logic             found;
        logic [PTR_W-1:0] win;
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        found = 1'b0;
        win   = {PTR_W{1'b0}};
        for (int k = 0; k < NUM_SOURCES; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= NUM_EXT) begin
                idx = PTR_W'(sum - NUM_EXT);
            end else begin
                idx = sum[PTR_W-1:0];
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end else begin
                found = found;
            end
        end
        return {found, win};
    endfunction

    assign w_can_load = !r_out_valid || BREADY;

    // Winner selection; the error path may pre-empt the round-robin search.
    always_comb begin
        w_found  = 1'b0;
        w_winner = {PTR_W{1'b0}};
`ifdef SLAVE_RESP_ERR_PRIORITY_EN
        if (src_bvalid[0]) begin
            w_found  = 1'b1;
            w_winner = {PTR_W{1'b0}};
        end else begin
            {w_found, w_winner} = rr_search(src_bvalid, r_rr_ptr);
        end
`else
        {w_found, w_winner} = rr_search(src_bvalid, r_rr_ptr);
`endif
    end

    assign w_src_hs = w_can_load && w_found;

    // One-hot accept to the winner; held at zero while the block is in reset.
    always_comb begin
        w_grant = {NUM_SOURCES{1'b0}};
        if (w_src_hs && ARESETn) begin
            w_grant[w_winner] = 1'b1;
        end else begin
            w_grant = {NUM_SOURCES{1'b0}};
        end
    end

    // Response field mux; driven only by the winner index, not by the fields themselves.
    always_comb begin
        w_sel_id   = {ID_WIDTH{1'b0}};
        w_sel_resp = {RESP_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (w_winner == PTR_W'(i)) begin
                w_sel_id   = src_bid[i*ID_WIDTH +: ID_WIDTH];
                w_sel_resp = src_bresp[i*RESP_WIDTH +: RESP_WIDTH];
            end else begin
                w_sel_id   = w_sel_id;
                w_sel_resp = w_sel_resp;
            end
        end
    end

    // Pointer advance past the winner; a priority win by source 0 leaves it untouched.
    always_comb begin
        w_next_ptr = r_rr_ptr;
`ifdef SLAVE_RESP_ERR_PRIORITY_EN
        if (w_winner == {PTR_W{1'b0}}) begin
            w_next_ptr = r_rr_ptr;
        end else if (w_winner == LAST_SRC) begin
            w_next_ptr = {PTR_W{1'b0}};
        end else begin
            w_next_ptr = w_winner + PTR_W'(1'b1);
        end
`else
        if (w_winner == LAST_SRC) begin
            w_next_ptr = {PTR_W{1'b0}};
        end else begin
            w_next_ptr = w_winner + PTR_W'(1'b1);
        end
`endif
    end

    // Output register and fairness pointer; a reload in the drain cycle avoids a bubble.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_out_valid <= 1'b0;
            r_out_id    <= {ID_WIDTH{1'b0}};
            r_out_resp  <= RESP_INVALID;
            r_rr_ptr    <= {PTR_W{1'b0}};
        end else if (w_src_hs) begin
            r_out_valid <= 1'b1;
            r_out_id    <= w_sel_id;
            r_out_resp  <= w_sel_resp;
            r_rr_ptr    <= w_next_ptr;
        end else if (r_out_valid && BREADY) begin
            r_out_valid <= 1'b0;
            r_out_id    <= {ID_WIDTH{1'b0}};
            r_out_resp  <= RESP_INVALID;
            r_rr_ptr    <= r_rr_ptr;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_id    <= r_out_id;
            r_out_resp  <= r_out_resp;
            r_rr_ptr    <= r_rr_ptr;
        end
    end

    assign src_bready = w_grant;
    assign BVALID     = r_out_valid;
    assign BID        = r_out_id;
    assign BRESP      = r_out_resp;

endmodule
